// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size encodings, response codes and
// the byte-lane mask decode used by AHB slaves.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    // Byte lanes touched by a transfer of 2^size bytes at the given lane offset.
    function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                             input logic [2:0] addr_lsbs,
                                             input int         data_w);
        logic [2:0]  off;
        logic [15:0] span;
        off = addr_lsbs & 3'((data_w / 8) - 1);
        if (size > HSIZE_DWORD)
            span = 16'h00ff;
        else
            span = (16'd1 << (16'd1 << size)) - 16'd1;
        return 8'(span) << off;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// DEPTH x DATA_W storage with a byte-enable synchronous write port and an
// asynchronous read port sharing one word address.
module ahb_sram_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b])
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture, legality decode, wait-state and
// two-cycle ERROR response FSM in front of a byte-writable memory.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int BYTES = DATA_W / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int LSB_W = (BL == 0) ? 1 : BL;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

    state_e            state, state_n;
    logic [3:0]        wcnt, wcnt_n;
    logic              vld_p1, vld_n;
    logic [IDX_W-1:0]  idx_p1;
    logic [BYTES-1:0]  mask_p1;
    logic              write_p1;
    logic [DATA_W-1:0] rdata_mem, hrdata_q;
    logic [ADDR_W-1:0] offset, align_mask;
    logic              ready, accept, legal, rd_cmpl, wr_en;

    assign ready     = (state == S_IDLE) || (state == S_ERR2);
    assign HREADYOUT = ready;
    assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    // Address phase (p0): acceptance and legality, all from bus inputs
    assign accept = HSEL && HREADY && ready &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    // Addresses below the base wrap to a large offset and fail the span test.
    assign offset     = HADDR - BASE_ADDR;
    assign align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
    assign legal      = ({1'b0, offset} < SPAN) && (HSIZE <= 3'(BL)) &&
                        ((HADDR & align_mask) == '0);

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1   <= offset[BL +: IDX_W];
            mask_p1  <= BYTES'(lane_mask(HSIZE, 3'(offset[LSB_W-1:0]), DATA_W));
            write_p1 <= HWRITE;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        vld_n   = vld_p1;
        case (state)
            S_IDLE, S_ERR2: begin
                state_n = S_IDLE;
                vld_n   = 1'b0;
                if (accept) begin
                    if (!legal) begin
                        state_n = S_ERR1;
                    end else begin
                        vld_n = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_n = S_WAIT;
                            wcnt_n  = 4'(WAIT_STATES - 1);
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd0)
                    state_n = S_IDLE;
                else
                    wcnt_n = wcnt - 4'd1;
            end
            S_ERR1:  state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wcnt     <= 4'd0;
            vld_p1   <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state  <= state_n;
            wcnt   <= wcnt_n;
            vld_p1 <= vld_n;
            if (rd_cmpl)
                hrdata_q <= rdata_mem;
        end
    end

    // Data phase (p1): completes when IDLE holds a pending transfer
    assign rd_cmpl = (state == S_IDLE) && vld_p1 && !write_p1;
    assign wr_en   = (state == S_IDLE) && vld_p1 && write_p1;
    assign HRDATA  = rd_cmpl ? rdata_mem : hrdata_q;

    ahb_sram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .be    (mask_p1),
        .addr  (idx_p1),
        .wdata (HWDATA),
        .rdata (rdata_mem)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: a zero-wait slave and a three-wait slave on one AHB-Lite bus.
module tb_ahb_sram_slave;

    localparam logic [31:0] B0 = 32'h4000_0000;
    localparam logic [31:0] B3 = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel0 = 1'b0, hsel3 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = '0;
    logic        hready;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, resp0, resp3;

    assign hready = rdy0 & rdy3;

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(B0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(B3), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
        .HRDATA(rd3), .HREADYOUT(rdy3), .HRESP(resp3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Single transfer; records the first data-phase cycle and the completing one.
    task automatic xfer(input bit s3, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rdat, output int lat,
                        output logic f_rdy, output logic f_resp, output logic resp);
        @(posedge clk); #1;
        hsel0 = !s3; hsel3 = s3; haddr = a; htrans = 2'd2; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        htrans = 2'd0; hwdata = wd;
        lat = 0; rdat = '0; resp = 1'b0; f_rdy = 1'b0; f_resp = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                f_rdy  = s3 ? rdy3 : rdy0;
                f_resp = s3 ? resp3 : resp0;
            end
            if (s3 ? rdy3 : rdy0) begin
                lat = c; resp = s3 ? resp3 : resp0; rdat = s3 ? rd3 : rd0;
                break;
            end
        end
    endtask

    task automatic wr_ok(input bit s3, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d, input string tag);
        logic [31:0] r; int lat; logic fr, fp, rp;
        xfer(s3, 1'b1, a, sz, d, r, lat, fr, fp, rp);
        chk({tag, "_lat"}, 32'(lat), s3 ? 32'd4 : 32'd1);
        chk({tag, "_resp"}, 32'(rp), 32'd0);
    endtask

    task automatic rd_ok(input bit s3, input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r; int lat; logic fr, fp, rp;
        xfer(s3, 1'b0, a, 3'd2, 32'h0, r, lat, fr, fp, rp);
        chk({tag, "_lat"}, 32'(lat), s3 ? 32'd4 : 32'd1);
        chk({tag, "_resp"}, 32'(rp), 32'd0);
        chk({tag, "_data"}, r, exp);
        if (s3) chk({tag, "_first_rdy"}, 32'(fr), 32'd0);
    endtask

    task automatic err_ok(input bit s3, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input string tag);
        logic [31:0] r; int lat; logic fr, fp, rp;
        xfer(s3, wr, a, sz, 32'hBAD0_BAD0, r, lat, fr, fp, rp);
        chk({tag, "_err1_rdy"}, 32'(fr), 32'd0);
        chk({tag, "_err1_resp"}, 32'(fp), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_err2_resp"}, 32'(rp), 32'd1);
    endtask

    // Pipelined slot list for the zero-wait slave.
    logic [1:0]  pt [16];
    logic        pw [16];
    logic [31:0] pa [16];
    logic [31:0] pd [16];
    int          np;

    task automatic add(input logic [1:0] t, input logic w, input logic [31:0] a, input logic [31:0] d);
        pt[np] = t; pw[np] = w; pa[np] = a; pd[np] = d;
        np++;
    endtask

    task automatic run_pipe(input string tag);
        logic [1:0]  t_prev;
        logic        w_prev;
        logic [31:0] d_prev, last_rd;
        bit          have_rd;
        t_prev = 2'd0; w_prev = 1'b0; d_prev = '0; last_rd = '0; have_rd = 1'b0;
        for (int s = 0; s <= np; s++) begin
            @(posedge clk); #1;
            hsel0 = 1'b1; hsel3 = 1'b0;
            if (w_prev) hwdata = d_prev;
            if (s < np) begin
                htrans = pt[s]; haddr = pa[s]; hwrite = pw[s]; hsize = 3'd2;
            end else begin
                htrans = 2'd0;
            end
            @(negedge clk);
            if (s > 0) begin
                chk({tag, "_rdy"}, 32'(rdy0), 32'd1);
                chk({tag, "_resp"}, 32'(resp0), 32'd0);
                if (t_prev[1] && !w_prev) begin
                    chk({tag, "_data"}, rd0, d_prev);
                    last_rd = d_prev; have_rd = 1'b1;
                end else if (t_prev == 2'd1 && have_rd) begin
                    chk({tag, "_busy_hold"}, rd0, last_rd);
                end
            end
            if (s < np) begin
                t_prev = pt[s]; w_prev = pw[s]; d_prev = pd[s];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy0", 32'(rdy0), 32'd1);
        chk("rst_resp0", 32'(resp0), 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_rdy3", 32'(rdy3), 32'd1);
        chk("rst_resp3", 32'(resp3), 32'd0);
        chk("rst_rdata3", rd3, 32'd0);
        rst_n = 1'b1;

        wr_ok(1'b0, B0 + 32'h10, 3'd2, 32'hDEAD_BEEF, "w0_wr");
        rd_ok(1'b0, B0 + 32'h10, 32'hDEAD_BEEF, "w0_rd");

        wr_ok(1'b1, B3 + 32'h8, 3'd2, 32'h1111_1111, "w3_wr");
        rd_ok(1'b1, B3 + 32'h8, 32'h1111_1111, "w3_rd");

        // Reset while the second write sits in its wait states
        @(posedge clk); #1;
        hsel0 = 1'b0; hsel3 = 1'b1; haddr = B3 + 32'h8; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'd0; hwdata = 32'h2222_2222;
        @(negedge clk);
        chk("rstw_pending_rdy", 32'(rdy3), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_rdy", 32'(rdy3), 32'd1);
        chk("rstw_resp", 32'(resp3), 32'd0);
        chk("rstw_rdata", rd3, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_ok(1'b1, B3 + 32'h8, 32'h1111_1111, "rstw_old");

        wr_ok(1'b0, B0 + 32'h20, 3'd2, 32'h0000_0000, "lane_init");
        wr_ok(1'b0, B0 + 32'h21, 3'd0, 32'hFFFF_AAFF, "lane_byte");
        wr_ok(1'b0, B0 + 32'h22, 3'd1, 32'h1234_EEEE, "lane_half");
        rd_ok(1'b0, B0 + 32'h20, 32'h1234_AA00, "lane_rd");

        wr_ok(1'b0, B0 + 32'h3FC, 3'd2, 32'h7777_5555, "top_wr");
        rd_ok(1'b0, B0 + 32'h3FC, 32'h7777_5555, "top_rd");

        wr_ok(1'b0, B0 + 32'h0, 3'd2, 32'h0123_4567, "e_init0");
        wr_ok(1'b0, B0 + 32'h30, 3'd2, 32'h89AB_CDEF, "e_init30");
        err_ok(1'b0, 1'b1, B0 + 32'h400, 3'd2, "e_range");
        err_ok(1'b0, 1'b1, B0 + 32'h30, 3'd3, "e_size");
        err_ok(1'b0, 1'b1, B0 + 32'h1, 3'd1, "e_align");
        err_ok(1'b0, 1'b0, B0 - 32'h4, 3'd2, "e_below");
        err_ok(1'b1, 1'b1, B3 + 32'h400, 3'd2, "e_w3");
        rd_ok(1'b0, B0 + 32'h0, 32'h0123_4567, "e_keep0");
        rd_ok(1'b0, B0 + 32'h30, 32'h89AB_CDEF, "e_keep30");

        np = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) add(2'd1, 1'b1, B0 + 32'h50, 32'h0);
            add((i == 0) ? 2'd2 : 2'd3, 1'b1, B0 + 32'h40 + 32'(4 * i), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101));
        end
        run_pipe("str_wr");

        np = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) add(2'd1, 1'b0, B0 + 32'h50, 32'h0);
            add((i == 0) ? 2'd2 : 2'd3, 1'b0, B0 + 32'h40 + 32'(4 * i), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101));
        end
        run_pipe("str_rd");

        np = 0;
        add(2'd2, 1'b1, B0 + 32'h80, 32'hCAFE_F00D);
        add(2'd2, 1'b0, B0 + 32'h80, 32'hCAFE_F00D);
        add(2'd2, 1'b1, B0 + 32'h80, 32'h0F0F_1234);
        add(2'd2, 1'b0, B0 + 32'h80, 32'h0F0F_1234);
        run_pipe("wr_rd");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
